qdec_nal_unpack: RTL and testbench

- Byte-stream front end for the HEVC decoder, placed between the bitstream FIFO and qdec_cabac.
- Finds Annex-B start codes and decodes the 2-byte NAL unit header.
- Strips emulation-prevention bytes (00 00 03 becomes 00 00).
- Forwards only the RBSP payload bytes to qdec_cabac on its bitstreamFetch valid/ready port.

---
 rtl/qdec_nal_unpack_pkg.sv | 28 ++
 rtl/qdec_nal_unpack_if.sv | 8 +
 rtl/qdec_nal_unpack.sv | 117 +++++++++++
 tb/tb_qdec_nal_unpack.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_nal_unpack_pkg.sv
// qdec_nal_unpack_pkg: state, constants and register bundle for the Annex-B NAL unpacker
package qdec_nal_unpack_pkg;
  typedef enum logic [2:0] {SEEK, HDR0, HDR1, PAYLOAD, FLUSH} t_nal_state_e;
  localparam logic [5:0] NAL_IDR_W_RADL = 6'd19;
  localparam logic [5:0] NAL_CRA = 6'd21;
  localparam logic [5:0] NAL_VPS = 6'd32;
  localparam logic [5:0] NAL_SPS = 6'd33;
  localparam logic [5:0] NAL_PPS = 6'd34;
  localparam logic [7:0] EPB_BYTE = 8'h03;
  // all-zero is the reset value, so SEEK must stay encoded as 0
  typedef struct packed {
    t_nal_state_e state;
    logic [1:0] zCnt;
    logic trail;
    logic seen;
    logic pendVld;
    logic [7:0] pend;
    logic [6:0] hdr0;
    logic [7:0] oData;
    logic oVld;
    logic [5:0] nalType;
    logic [5:0] layer;
    logic [2:0] tid;
    logic hdrVld;
    logic nalEnd;
    logic err;
  } t_nal_regs_s;
endpackage

// File: rtl/qdec_nal_unpack_if.sv
// qdec_nal_unpack_if: byte-wide valid/ready stream channel
interface qdec_nal_unpack_if;
  logic [7:0] data;
  logic vld;
  logic rdy;
  modport master(output data, vld, input rdy);
  modport slave(input data, vld, output rdy);
endinterface

// File: rtl/qdec_nal_unpack.sv
// qdec_nal_unpack: start-code search, NAL header decode and emulation-prevention removal
module qdec_nal_unpack
  import qdec_nal_unpack_pkg::*;
#(
  parameter int EPB_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 soft_clr,
  qdec_nal_unpack_if.slave     din,
  qdec_nal_unpack_if.master    dout,
  output logic [5:0]           nal_type,
  output logic [5:0]           nuh_layer_id,
  output logic [2:0]           nuh_tid_plus1,
  output logic                 nal_hdr_vld,
  output logic                 nal_end,
  output logic                 err,
  output logic [EPB_CNT_W-1:0] epb_cnt
);
  t_nal_regs_s r, n;
  logic [EPB_CNT_W-1:0] epbNxt;
  logic outFree, acc;
  logic [7:0] b;
  assign outFree = !r.oVld || dout.rdy;
  assign din.rdy = (r.state != FLUSH) && outFree;
  assign acc = din.vld && din.rdy;
  assign b = din.data;
  assign dout.data = r.oData;
  assign dout.vld = r.oVld;
  assign nal_type = r.nalType;
  assign nuh_layer_id = r.layer;
  assign nuh_tid_plus1 = r.tid;
  assign nal_hdr_vld = r.hdrVld;
  assign nal_end = r.nalEnd;
  assign err = r.err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      epb_cnt <= '0;
    end else if (soft_clr) begin
      r <= '0;
      epb_cnt <= '0;
    end else begin
      r <= n;
      epb_cnt <= epbNxt;
    end
  end
  always_comb begin
    n = r;
    n.hdrVld = 1'b0;
    n.nalEnd = 1'b0;
    n.err = 1'b0;
    n.oVld = r.oVld && !dout.rdy;
    epbNxt = epb_cnt;
    if (acc) begin
      case (r.state)
        SEEK: begin
          n.zCnt = (b != 8'h00) ? 2'd0 : (r.zCnt == 2'd2) ? 2'd2 : r.zCnt + 2'd1;
          if (b == 8'h01 && r.zCnt == 2'd2) n.state = HDR0;
        end
        HDR0: begin
          n.hdr0 = b[6:0];
          n.err = b[7];
          n.state = HDR1;
        end
        HDR1: begin
          n.nalType = r.hdr0[6:1];
          n.layer = {r.hdr0[0], b[7:3]};
          n.tid = b[2:0];
          n.hdrVld = 1'b1;
          n.err = (b[2:0] == 3'd0);
          n.state = PAYLOAD;
          n.zCnt = 2'd0;
          n.seen = 1'b0;
          n.trail = 1'b0;
        end
        PAYLOAD: begin
          if (b == 8'h00) begin
            if (r.zCnt == 2'd2) n.trail = 1'b1;
            else n.zCnt = r.zCnt + 2'd1;
          end else if (b == 8'h01 && r.zCnt == 2'd2) begin
            n.nalEnd = r.seen;
            n.state = HDR0;
            n.zCnt = 2'd0;
            n.trail = 1'b0;
          end else if (b == EPB_BYTE && r.zCnt == 2'd2 && !r.trail) begin
            // the two held zeros are real data and still have to be emitted
            epbNxt = (&epb_cnt) ? epb_cnt : epb_cnt + 1'b1;
            n.pendVld = 1'b0;
            n.state = FLUSH;
          end else begin
            n.err = r.trail || (b == 8'h02 && r.zCnt == 2'd2);
            if (r.zCnt == 2'd0) begin
              n.oData = b;
              n.oVld = 1'b1;
              n.seen = 1'b1;
            end else begin
              n.pend = b;
              n.pendVld = 1'b1;
              n.state = FLUSH;
            end
          end
        end
        default: ;
      endcase
    end else if (r.state == FLUSH && outFree) begin
      n.oVld = 1'b1;
      n.oData = (r.zCnt != 2'd0) ? 8'h00 : r.pend;
      n.zCnt = (r.zCnt != 2'd0) ? r.zCnt - 2'd1 : 2'd0;
      if (r.zCnt == 2'd0 || (r.zCnt == 2'd1 && !r.pendVld)) begin
        n.state = PAYLOAD;
        n.trail = 1'b0;
        n.seen = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_qdec_nal_unpack.sv
// tb_qdec_nal_unpack: directed vectors plus randomized NAL streams checked against an RBSP-level model
module tb_qdec_nal_unpack;
  import qdec_nal_unpack_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic soft_clr = 1'b0;
  logic [5:0] nal_type, nuh_layer_id;
  logic [2:0] nuh_tid_plus1;
  logic nal_hdr_vld, nal_end, err;
  logic [15:0] epb_cnt;
  int nPass = 0, nTot = 0;
  qdec_nal_unpack_if inIf ();
  qdec_nal_unpack_if outIf ();
  qdec_nal_unpack #(.EPB_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .din(inIf), .dout(outIf),
    .nal_type(nal_type), .nuh_layer_id(nuh_layer_id), .nuh_tid_plus1(nuh_tid_plus1),
    .nal_hdr_vld(nal_hdr_vld), .nal_end(nal_end), .err(err), .epb_cnt(epb_cnt)
  );
  always #5 clk = ~clk;

  typedef struct {
    int nIn;
    logic [127:0] in;
    int nOut;
    logic [63:0] out;
    logic [14:0] hdr;
    int nHdr;
    int nErr;
    int nEnd;
    int epb;
  } vec_t;
  vec_t vecs[7];

  logic [7:0] got[$];
  logic [14:0] hdrGot[$];
  int errCnt = 0, endCnt = 0;
  logic prevHold = 1'b0;
  logic [7:0] prevData = 8'h00;
  bit randRdy = 1'b0;
  logic rdyForce = 1'b1;
  logic [7:0] stream[$], expOut[$];
  logic [14:0] expHdr[$];
  int expEpb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTot++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    #2;
    outIf.rdy = randRdy ? ($urandom_range(0, 3) != 0) : rdyForce;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (outIf.vld && outIf.rdy) got.push_back(outIf.data);
      if (nal_hdr_vld) hdrGot.push_back({nal_type, nuh_layer_id, nuh_tid_plus1});
      errCnt += int'(err);
      endCnt += int'(nal_end);
      if (prevHold) check("holdWhileStalled", {23'd0, outIf.vld, outIf.data}, {23'd0, 1'b1, prevData});
    end
    prevHold = rst_n && outIf.vld && !outIf.rdy;
    prevData = outIf.data;
  end

  task automatic clearObs();
    got.delete();
    hdrGot.delete();
    errCnt = 0;
    endCnt = 0;
  endtask

  task automatic softClear();
    @(posedge clk);
    #1 soft_clr = 1'b1;
    @(posedge clk);
    #1 soft_clr = 1'b0;
    clearObs();
  endtask

  task automatic sendByte(input logic [7:0] b);
    int t;
    t = 0;
    inIf.data = b;
    inIf.vld = 1'b1;
    @(negedge clk);
    while (!inIf.rdy) begin
      t++;
      if (t > 500) begin
        $display("FAIL sendTimeout: din_rdy stuck low with byte %0h, required high within 500 cycles", b);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 inIf.vld = 1'b0;
  endtask

  // encoder view: wrap random RBSPs in start codes and insert EPBs; the unpacker must return the RBSPs
  task automatic buildStream(input int nNal);
    logic [5:0] t, l;
    logic [2:0] tid;
    logic [7:0] rb[$];
    int z;
    stream.delete();
    expOut.delete();
    expHdr.delete();
    expEpb = 0;
    for (int k = 0; k <= nNal; k++) begin
      repeat ($urandom_range(0, 2)) stream.push_back(8'h00);
      stream.push_back(8'h00);
      stream.push_back(8'h00);
      stream.push_back(8'h01);
      t = 6'($urandom_range(0, 63));
      l = 6'($urandom_range(0, 63));
      tid = 3'($urandom_range(1, 7));
      stream.push_back({1'b0, t, l[5]});
      stream.push_back({l[4:0], tid});
      expHdr.push_back({t, l, tid});
      if (k < nNal) begin
        rb.delete();
        repeat ($urandom_range(1, 24)) rb.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(0, 255)));
        if (rb[rb.size()-1] == 8'h00) rb[rb.size()-1] = 8'h80;
        z = 0;
        foreach (rb[i]) begin
          if (z == 2 && rb[i] <= 8'h03) begin
            stream.push_back(EPB_BYTE);
            expEpb++;
            z = 0;
          end
          stream.push_back(rb[i]);
          z = (rb[i] == 8'h00) ? z + 1 : 0;
          expOut.push_back(rb[i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lowCnt;
    vecs[0] = '{7, 128'h00000140_01AABB, 2, 64'hAABB, {NAL_VPS, 6'd0, 3'd1}, 1, 0, 0, 0};
    vecs[1] = '{11, 128'h00000140_01120000_030134, 5, 64'h12000001_34, {NAL_VPS, 6'd0, 3'd1}, 1, 0, 0, 1};
    vecs[2] = '{13, 128'h00000001_2601C000_00000142_01, 1, 64'hC0, {NAL_SPS, 6'd0, 3'd1}, 2, 0, 1, 0};
    vecs[3] = '{8, 128'h00000180_01000002, 3, 64'h000002, {6'd0, 6'd0, 3'd1}, 1, 2, 0, 0};
    vecs[4] = '{6, 128'h0000012A_00AA, 1, 64'hAA, {NAL_CRA, 6'd0, 3'd0}, 1, 1, 0, 0};
    vecs[5] = '{9, 128'h050001_00000144_0155, 1, 64'h55, {NAL_PPS, 6'd0, 3'd1}, 1, 0, 0, 0};
    vecs[6] = '{9, 128'h00000126_01000500_02, 4, 64'h00050002, {NAL_IDR_W_RADL, 6'd0, 3'd1}, 1, 0, 0, 0};
    inIf.data = 8'h00;
    inIf.vld = 1'b0;
    #1;
    check("resetOutputs", {epb_cnt, outIf.vld, outIf.data, nal_hdr_vld, nal_end, err},
          32'd0);
    check("resetHeader", {nal_type, nuh_layer_id, nuh_tid_plus1}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      softClear();
      for (int i = 0; i < vecs[v].nIn; i++) sendByte(vecs[v].in[8*(vecs[v].nIn-1-i) +: 8]);
      repeat (8) @(negedge clk);
      check($sformatf("vec%0d.outLen", v), got.size(), vecs[v].nOut);
      for (int i = 0; i < vecs[v].nOut && i < got.size(); i++)
        check($sformatf("vec%0d.out%0d", v, i), got[i], vecs[v].out[8*(vecs[v].nOut-1-i) +: 8]);
      check($sformatf("vec%0d.header", v), {nal_type, nuh_layer_id, nuh_tid_plus1}, vecs[v].hdr);
      check($sformatf("vec%0d.hdrPulses", v), hdrGot.size(), vecs[v].nHdr);
      check($sformatf("vec%0d.errPulses", v), errCnt, vecs[v].nErr);
      check($sformatf("vec%0d.endPulses", v), endCnt, vecs[v].nEnd);
      check($sformatf("vec%0d.epbCnt", v), epb_cnt, vecs[v].epb);
    end

    // output latency and back-pressure
    softClear();
    foreach (vecs[0].in[i]) if (i >= 16 && i < 56 && (i % 8) == 0) ;
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h01); sendByte(8'h40); sendByte(8'h01);
    rdyForce = 1'b0;
    sendByte(8'hAB);
    check("latencyOne", {outIf.vld, outIf.data}, {1'b1, 8'hAB});
    repeat (5) begin
      @(negedge clk);
      check("stallHold", {outIf.vld, outIf.data, inIf.rdy}, {1'b1, 8'hAB, 1'b0});
    end
    rdyForce = 1'b1;
    sendByte(8'hCD);
    sendByte(8'hEF);
    repeat (6) @(negedge clk);
    check("stallSeqLen", got.size(), 3);
    if (got.size() == 3) check("stallSeq", {got[0], got[1], got[2]}, 24'hABCDEF);

    // din stall while the held zeros of an EPB are flushed
    softClear();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h01); sendByte(8'h40); sendByte(8'h01);
    sendByte(8'h12); sendByte(8'h00); sendByte(8'h00); sendByte(8'h03);
    lowCnt = 0;
    repeat (6) begin
      @(negedge clk);
      lowCnt += int'(!inIf.rdy);
    end
    check("flushStallCycles", lowCnt, 2);

    // asynchronous reset in the middle of a flush
    softClear();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h01); sendByte(8'h40); sendByte(8'h01);
    sendByte(8'h11); sendByte(8'h00); sendByte(8'h00); sendByte(8'h05);
    @(negedge clk);
    check("flushDinStalled", inIf.rdy, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midFlushReset", {epb_cnt, outIf.vld, outIf.data, nal_hdr_vld, nal_end, err}, 32'd0);
    check("midFlushResetHdr", {nal_type, nuh_layer_id, nuh_tid_plus1}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clearObs();
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h01); sendByte(8'h44); sendByte(8'h01); sendByte(8'h77);
    repeat (6) @(negedge clk);
    check("recoverLen", got.size(), 1);
    if (got.size() == 1) check("recoverByte", got[0], 8'h77);
    check("recoverType", nal_type, NAL_PPS);

    // random NAL streams with random input gaps and output back-pressure
    for (int rnd = 0; rnd < 2; rnd++) begin
      softClear();
      buildStream(8);
      randRdy = 1'b1;
      foreach (stream[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat (2) @(posedge clk);
          #1;
        end
        sendByte(stream[i]);
      end
      randRdy = 1'b0;
      repeat (30) @(negedge clk);
      check($sformatf("rnd%0d.outLen", rnd), got.size(), expOut.size());
      for (int i = 0; i < expOut.size() && i < got.size(); i++)
        check($sformatf("rnd%0d.out%0d", rnd, i), got[i], expOut[i]);
      check($sformatf("rnd%0d.hdrCount", rnd), hdrGot.size(), expHdr.size());
      for (int i = 0; i < expHdr.size() && i < hdrGot.size(); i++)
        check($sformatf("rnd%0d.hdr%0d", rnd, i), hdrGot[i], expHdr[i]);
      check($sformatf("rnd%0d.epbCnt", rnd), epb_cnt, expEpb);
      check($sformatf("rnd%0d.errPulses", rnd), errCnt, 0);
      check($sformatf("rnd%0d.endPulses", rnd), endCnt, 8);
    end

    $display("%0d/%0d checks passed", nPass, nTot);
    $finish;
  end
endmodule
